// File: rtl/branch_ctrl_pkg.sv
// Shared types for the branch controller: datapath width, opcodes and FSM states.
// Helpers decode which opcodes are handled and which operands each one needs.
package branch_ctrl_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] data_t;
  typedef logic [6:0]      opcode_t;

  localparam opcode_t BRANCH = 7'b1100011;
  localparam opcode_t JALR   = 7'b1100111;
  localparam opcode_t JAL    = 7'b1101111;

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} br_state_t;

  function automatic logic is_bj_op(input opcode_t op);
    return (op == BRANCH) || (op == JALR) || (op == JAL);
  endfunction

  // JAL resolves on pc + imm alone, so it never waits for operands.
  function automatic logic ops_ready(input opcode_t op, input logic ok1, input logic ok2);
    case (op)
      BRANCH:  return ok1 & ok2;
      JALR:    return ok1;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode/fetch-facing bundle of the branch controller; master drives requests,
// slave is the controller view.
interface branch_ctrl_if #(
  parameter int CNT_W = 16
);
  import branch_ctrl_pkg::*;

  logic             br_valid;
  logic             br_ready;
  data_t            br_instr;
  data_t            br_pc;
  data_t            rs1;
  data_t            rs2;
  logic             rs1_ok;
  logic             rs2_ok;
  logic             kill;
  logic             stall_de;
  logic             redirect_valid;
  logic             redirect_ready;
  data_t            redirect_pc;
  logic             flush;
  logic             resolve_done;
  logic             misalign_err;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output br_valid, br_instr, br_pc, rs1, rs2, rs1_ok, rs2_ok, kill, redirect_ready,
    input  br_ready, stall_de, redirect_valid, redirect_pc, flush, resolve_done,
           misalign_err, br_cnt, taken_cnt
  );

  modport slave (
    input  br_valid, br_instr, br_pc, rs1, rs2, rs1_ok, rs2_ok, kill, redirect_ready,
    output br_ready, stall_de, redirect_valid, redirect_pc, flush, resolve_done,
           misalign_err, br_cnt, taken_cnt
  );

endinterface

// File: rtl/branch_ctrl_pc_adder.sv
// Combinational branch/jump resolver: take decision and target for BRANCH, JAL, JALR.
// Zero latency; no flow control.
module pc_adder
  import branch_ctrl_pkg::*;
(
  input  data_t instr,
  input  data_t pc,
  input  data_t rs1,
  input  data_t rs2,
  output logic  bj_sel,
  output data_t pc_bj
);

  data_t imm_b, imm_i, imm_j;

  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_i = {{21{instr[31]}}, instr[30:20]};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    bj_sel = 1'b0;
    pc_bj  = pc + imm_b;
    case (instr[6:0])
      BRANCH: begin
        case (instr[14:12])
          3'b000:  bj_sel = (rs1 == rs2);
          3'b001:  bj_sel = (rs1 != rs2);
          3'b100:  bj_sel = ($signed(rs1) <  $signed(rs2));
          3'b101:  bj_sel = ($signed(rs1) >= $signed(rs2));
          3'b110:  bj_sel = (rs1 <  rs2);
          3'b111:  bj_sel = (rs1 >= rs2);
          default: bj_sel = 1'b0;
        endcase
      end
      JAL: begin
        bj_sel = 1'b1;
        pc_bj  = pc + imm_j;
      end
      JALR: begin
        bj_sel = 1'b1;
        pc_bj  = (rs1 + imm_i) & ~data_t'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Single-entry branch resolver: accept in IDLE, resolve in EVAL (1 cycle once operands ok),
// then hold a redirect until fetch accepts it and keep flush up for FLUSH_CYC cycles.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input logic        clk,
  input logic        rst,
  branch_ctrl_if.slave bus
);

  localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYC == 0) ? 4'd0 : 4'(FLUSH_CYC - 1);

  br_state_t        state_q, state_d;
  data_t            instr_q, instr_d;
  data_t            pc_q, pc_d;
  data_t            redirect_pc_q, redirect_pc_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic  bj_sel;
  data_t pc_bj;
  logic  ops_ok, misalign, resolve_go, rd_hs;

  pc_adder u_pc_adder (
    .instr  (instr_q),
    .pc     (pc_q),
    .rs1    (bus.rs1),
    .rs2    (bus.rs2),
    .bj_sel (bj_sel),
    .pc_bj  (pc_bj)
  );

  assign ops_ok     = ops_ready(instr_q[6:0], bus.rs1_ok, bus.rs2_ok);
  assign misalign   = (pc_bj[1:0] != 2'b00);
  assign resolve_go = (state_q == EVAL) && !bus.kill && ops_ok;
  assign rd_hs      = (state_q == REDIRECT) && bus.redirect_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      pc_q          <= '0;
      redirect_pc_q <= '0;
      flush_cnt_q   <= '0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      flush_cnt_q   <= flush_cnt_d;
      br_cnt_q      <= br_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    flush_cnt_d   = flush_cnt_q;
    br_cnt_d      = br_cnt_q;
    taken_cnt_d   = taken_cnt_q;
    case (state_q)
      IDLE: begin
        // Non-branch opcodes are consumed here and simply vanish.
        if (bus.br_valid && !bus.kill && is_bj_op(bus.br_instr[6:0])) begin
          instr_d = bus.br_instr;
          pc_d    = bus.br_pc;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (bus.kill) begin
          state_d = IDLE;
        end else if (ops_ok) begin
          br_cnt_d = (br_cnt_q == '1) ? br_cnt_q : br_cnt_q + 1'b1;
          if (bj_sel && !misalign) begin
            taken_cnt_d   = (taken_cnt_q == '1) ? taken_cnt_q : taken_cnt_q + 1'b1;
            redirect_pc_d = pc_bj;
            state_d       = REDIRECT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          if (FLUSH_CYC == 0) begin
            state_d = IDLE;
          end else begin
            flush_cnt_d = FLUSH_LOAD;
            state_d     = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 4'd0) state_d = IDLE;
        else                     flush_cnt_d = flush_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.br_ready       = (state_q == IDLE) && !bus.kill;
    bus.stall_de       = ((state_q == EVAL) && !ops_ok) || (state_q == REDIRECT);
    bus.redirect_valid = (state_q == REDIRECT);
    bus.flush          = (state_q == REDIRECT) || (state_q == FLUSH);
    bus.resolve_done   = (resolve_go && (!bj_sel || misalign))
                       || (rd_hs && (FLUSH_CYC == 0))
                       || ((state_q == FLUSH) && (flush_cnt_q == 4'd0));
    bus.misalign_err   = resolve_go && bj_sel && misalign;
  end

  assign bus.redirect_pc = redirect_pc_q;
  assign bus.br_cnt      = br_cnt_q;
  assign bus.taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed branches feed a scoreboard queue, a negedge monitor
// checks every resolution; a CNT_W=4 copy shares the stimulus for saturation.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  typedef enum int {K_NT, K_TAKEN, K_MIS} kind_e;
  typedef struct {
    int          kind;
    logic [31:0] target;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_br;
  int   exp_tk;
  exp_t sb[$];

  branch_ctrl_if #(.CNT_W(16)) bi ();
  branch_ctrl_if #(.CNT_W(4))  bs ();

  assign bs.br_valid       = bi.br_valid;
  assign bs.br_instr       = bi.br_instr;
  assign bs.br_pc          = bi.br_pc;
  assign bs.rs1            = bi.rs1;
  assign bs.rs2            = bi.rs2;
  assign bs.rs1_ok         = bi.rs1_ok;
  assign bs.rs2_ok         = bi.rs2_ok;
  assign bs.kill           = bi.kill;
  assign bs.redirect_ready = bi.redirect_ready;

  branch_ctrl #(.FLUSH_CYC(2), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bi.slave));
  branch_ctrl #(.FLUSH_CYC(2), .CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bs.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bi.br_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic ok1, input logic ok2,
                       input bit push, input int kind, input logic [31:0] tgt);
    exp_t e;
    wait_idle();
    bi.br_instr = instr;
    bi.br_pc    = pc;
    bi.rs1      = r1;
    bi.rs2      = r2;
    bi.rs1_ok   = ok1;
    bi.rs2_ok   = ok2;
    bi.br_valid = 1'b1;
    if (push) begin
      e.kind   = kind;
      e.target = tgt;
      sb.push_back(e);
    end
    tick();
    bi.br_valid = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    int sat_br, sat_tk;
    sat_br = (exp_br > 15) ? 15 : exp_br;
    sat_tk = (exp_tk > 15) ? 15 : exp_tk;
    chk({tag, "_br_cnt"},      32'(bi.br_cnt),    exp_br);
    chk({tag, "_taken_cnt"},   32'(bi.taken_cnt), exp_tk);
    chk({tag, "_br_cnt4"},     32'(bs.br_cnt),    sat_br);
    chk({tag, "_taken_cnt4"},  32'(bs.taken_cnt), sat_tk);
  endtask

  // Monitor: every resolution or redirect seen on the bus consumes the queue head.
  bit in_flush;
  int flush_cyc;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_flush  = 1'b0;
      flush_cyc = 0;
    end else if (bi.redirect_valid) begin
      if (sb.size() == 0) begin
        chk("redirect_unexpected", 32'd1, 32'd0);
      end else begin
        chk("redirect_kind", sb[0].kind, K_TAKEN);
        chk("redirect_pc", bi.redirect_pc, sb[0].target);
        chk("redirect_flush", {30'd0, bi.flush, bi.stall_de}, 32'd3);
        if (bi.redirect_ready) begin
          e = sb.pop_front();
          in_flush  = 1'b1;
          flush_cyc = 0;
        end
      end
    end else if (in_flush) begin
      if (bi.flush) flush_cyc++;
      chk("flush_stall_de", {31'd0, bi.stall_de}, 32'd0);
      if (bi.resolve_done) begin
        chk("flush_len", flush_cyc, 2);
        in_flush = 1'b0;
      end
    end else if (bi.resolve_done) begin
      if (sb.size() == 0) begin
        chk("resolve_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resolve_kind", bi.misalign_err ? K_MIS : K_NT, e.kind);
      end
    end else if (bi.misalign_err) begin
      chk("misalign_without_resolve", 32'd1, 32'd0);
    end
  end

  initial begin
    int stall_cnt;
    checks   = 0;
    failures = 0;
    exp_br   = 0;
    exp_tk   = 0;
    rst               = 1'b1;
    bi.br_valid       = 1'b0;
    bi.br_instr       = '0;
    bi.br_pc          = '0;
    bi.rs1            = '0;
    bi.rs2            = '0;
    bi.rs1_ok         = 1'b1;
    bi.rs2_ok         = 1'b1;
    bi.kill           = 1'b0;
    bi.redirect_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_br_ready", {31'd0, bi.br_ready}, 32'd1);
    chk("rst_outputs", {27'd0, bi.redirect_valid, bi.flush, bi.stall_de,
                        bi.resolve_done, bi.misalign_err}, 32'd0);
    chk("rst_redirect_pc", bi.redirect_pc, 32'd0);
    chk_cnt("rst");

    // Not-taken BEQ 5 vs 6: resolves in the first EVAL cycle
    issue(enc_b(3'b000, 13'd8), 32'h80, 32'd5, 32'd6, 1'b1, 1'b1, 1'b1, K_NT, 32'h0);
    chk("nt_resolve_now", {31'd0, bi.resolve_done}, 32'd1);
    exp_br++;
    wait_idle();
    chk_cnt("nt");

    // Taken BNE at 0x100 +8 with redirect_ready low for three REDIRECT cycles
    bi.redirect_ready = 1'b0;
    issue(enc_b(3'b001, 13'd8), 32'h100, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1, K_TAKEN, 32'h108);
    tick();
    chk("bp_in_redirect", {31'd0, bi.redirect_valid}, 32'd1);
    repeat (3) tick();
    bi.redirect_ready = 1'b1;
    exp_br++;
    exp_tk++;
    wait_idle();
    chk_cnt("bp");

    // JALR waiting 4 cycles on rs1_ok; rs2_ok is irrelevant. 0x1000+0x15 -> 0x1014
    issue(enc_jalr(12'h015), 32'h200, 32'h1000, 32'h0, 1'b0, 1'b0, 1'b1, K_TAKEN, 32'h1014);
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bi.stall_de) stall_cnt++;
      tick();
    end
    bi.rs1_ok = 1'b1;
    #1;
    chk("jalr_stall_cycles", stall_cnt, 4);
    chk("jalr_stall_release", {31'd0, bi.stall_de}, 32'd0);
    exp_br++;
    exp_tk++;
    wait_idle();
    bi.rs2_ok = 1'b1;

    // JAL needs no operands: 0x300 + 0x40
    issue(enc_jal(21'h40), 32'h300, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, K_TAKEN, 32'h340);
    exp_br++;
    exp_tk++;
    wait_idle();
    bi.rs1_ok = 1'b1;
    bi.rs2_ok = 1'b1;
    chk_cnt("jal");

    // Kill beats an otherwise taken resolution
    issue(enc_b(3'b000, 13'd8), 32'h500, 32'd9, 32'd9, 1'b1, 1'b1, 1'b0, K_NT, 32'h0);
    bi.kill = 1'b1;
    #1;
    chk("kill_no_resolve", {30'd0, bi.resolve_done, bi.misalign_err}, 32'd0);
    chk("kill_br_ready", {31'd0, bi.br_ready}, 32'd0);
    tick();
    bi.kill = 1'b0;
    #1;
    chk("kill_idle", {31'd0, bi.br_ready}, 32'd1);
    chk_cnt("kill");

    // Misaligned taken branch: 0x600 + 6 = 0x606
    issue(enc_b(3'b000, 13'd6), 32'h600, 32'd7, 32'd7, 1'b1, 1'b1, 1'b1, K_MIS, 32'h606);
    chk("mis_pulse", {31'd0, bi.misalign_err}, 32'd1);
    exp_br++;
    wait_idle();
    chk_cnt("mis");

    // Non-branch opcode is consumed without leaving IDLE
    issue(32'h00000013, 32'h700, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, K_NT, 32'h0);
    chk("drop_still_idle", {30'd0, bi.br_ready, bi.stall_de}, 32'd2);
    bi.rs1_ok = 1'b1;
    bi.rs2_ok = 1'b1;
    chk_cnt("drop");

    // Reset while a redirect is pending, with the handshake offered in the same cycle
    bi.redirect_ready = 1'b0;
    issue(enc_b(3'b001, 13'd8), 32'h800, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1, K_TAKEN, 32'h808);
    tick();
    chk("rstr_in_redirect", {31'd0, bi.redirect_valid}, 32'd1);
    rst = 1'b1;
    bi.redirect_ready = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    exp_br = 0;
    exp_tk = 0;
    #1;
    chk("rstr_redirect_valid", {30'd0, bi.redirect_valid, bi.flush}, 32'd0);
    chk("rstr_br_ready", {31'd0, bi.br_ready}, 32'd1);
    chk("rstr_redirect_pc", bi.redirect_pc, 32'd0);
    chk_cnt("rstr");

    // 20 taken BLTs (-1 < 1): wide counters reach 20, 4-bit copies stick at 15
    for (int i = 0; i < 20; i++) begin
      issue(enc_b(3'b100, 13'd16), 32'h400, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1,
            1'b1, K_TAKEN, 32'h410);
      exp_br++;
      exp_tk++;
    end
    wait_idle();
    chk_cnt("sat");

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter XLEN, 32, datapath width; taken from the shared package.
REQ-002 Parameter FLUSH_CYC, 2, cycles that flush stays asserted after a redirect is accepted; legal range 0-15.
REQ-003 Parameter CNT_W, 16, width of the statistics counters.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 br_valid  input  1  decode presents a branch/jump.
REQ-007 br_ready  output  1  controller accepts br_valid this cycle.
REQ-008 br_instr  input  XLEN  instruction word.
REQ-009 br_pc  input  XLEN  instruction PC.
REQ-010 rs1, rs2  input  XLEN  forwarded operand values.
REQ-011 rs1_ok, rs2_ok  input  1  each operand is valid this cycle.
REQ-012 kill  input  1  older-instruction flush; aborts an unresolved branch.
REQ-013 stall_de  output  1  hold the decode stage.
REQ-014 redirect_valid  output  1  redirect request to fetch.
REQ-015 redirect_ready  input  1  fetch accepts the redirect.
REQ-016 redirect_pc  output  XLEN  target PC.
REQ-017 flush  output  1  kill the IF/ID contents.
REQ-018 resolve_done  output  1  one-cycle pulse when a branch retires from the controller.
REQ-019 misalign_err  output  1  one-cycle pulse when the target satisfies target[1:0] != 0.
REQ-020 br_cnt, taken_cnt  output  CNT_W  resolved-branch count and taken-branch count.

Function
REQ-021 States: IDLE, EVAL, REDIRECT, FLUSH.
REQ-022 br_ready SHALL be 1 only in IDLE with kill=0.
REQ-023 IDLE acceptance (br_valid & br_ready) SHALL capture br_instr and br_pc into registers and go to EVAL; branch, JALR and JAL opcodes only.
REQ-024 In IDLE, br_valid with any other opcode SHALL be accepted and dropped; no state change, no counter change.
REQ-025 The captured instr/pc plus rs1/rs2 SHALL drive the internal pc_adder; its bj_sel and pc_bj are the take and target.
REQ-026 Operand requirement in EVAL: BRANCH needs rs1_ok & rs2_ok; JALR needs rs1_ok; JAL needs none.
REQ-027 In EVAL, stall_de=1 until the required operands are ok.
REQ-028 kill=1 in EVAL SHALL return to IDLE next cycle, with no pulse and no counter update; kill has priority over resolution.
REQ-029 When operands are ok and bj_sel=0, EVAL SHALL go to IDLE, pulse resolve_done, and increment br_cnt (1-cycle resolve).
REQ-030 When operands are ok, bj_sel=1 and pc_bj[1:0]=0, EVAL SHALL register pc_bj into redirect_pc, increment br_cnt and taken_cnt, and go to REDIRECT.
REQ-031 When bj_sel=1 and pc_bj[1:0]!=0, EVAL SHALL pulse misalign_err and resolve_done, increment br_cnt only, and go to IDLE without redirect.
REQ-032 In REDIRECT: redirect_valid=1, flush=1, stall_de=1; redirect_pc stays stable until redirect_ready.
REQ-033 Handshake in REDIRECT (redirect_valid & redirect_ready): go to FLUSH, loading the down-counter with FLUSH_CYC-1; if FLUSH_CYC=0, go to IDLE and pulse resolve_done.
REQ-034 In FLUSH: flush=1, stall_de=0, counter decrements; at 0, go to IDLE and pulse resolve_done that cycle.
REQ-035 kill SHALL be ignored in REDIRECT and FLUSH, because the redirect is already committed.
REQ-036 Counters SHALL saturate at all-ones and never wrap.
REQ-037 At most one branch in flight; br_ready=0 outside IDLE.

Reset
REQ-038 rst=1 SHALL, at the next edge, force IDLE with all outputs 0 except br_ready=1, and clear redirect_pc, counters and captured registers.
REQ-039 rst has priority over every other input in any state, including a pending redirect handshake.

Structure
REQ-040 XLEN, data_t, opcode constants (BRANCH, JAL, JALR) and the br_state_t enum SHALL live in the shared package.
REQ-041 branch_ctrl SHALL instantiate exactly one sub-module, pc_adder; there is no other hierarchy.

Verification
REQ-042 Not-taken: BEQ with rs1=5, rs2=6 and ops ok -> resolve_done 1 cycle after EVAL entry, redirect_valid never 1, br_cnt=1.
REQ-043 Taken + backpressure: BNE at pc=0x100, offset +8, redirect_ready low 3 cycles -> redirect_pc=0x108 held stable, then flush high FLUSH_CYC=2 cycles, taken_cnt=1.
REQ-044 Operand stall: JALR with rs1_ok low 4 cycles -> stall_de high 4 cycles, then redirect to rs1+imm with bit0 cleared.
REQ-045 Kill/misalign: kill in EVAL -> IDLE, counters unchanged; target ending in 2'b10 -> misalign_err pulse, no redirect.
REQ-046 Reset in REDIRECT: rst for 1 cycle -> next cycle IDLE, redirect_valid=0, counters=0.
REQ-047 Saturation: CNT_W=4 with 20 taken BLTs (rs1=-1, rs2=1) -> br_cnt=taken_cnt=15.
